// File: rtl/cmd_seq_pkg.sv
// rtl/cmd_seq_pkg.sv - shared types for the SD command queue sequencer
package cmd_seq_pkg;

    localparam logic [1:0] RSP_NONE  = 2'b00;
    localparam logic [1:0] RSP_LONG  = 2'b01;
    localparam logic [1:0] RSP_SHORT = 2'b10;
    localparam logic [1:0] RSP_BUSY  = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WRITE,
        SWITCH,
        READ,
        READ_BUSY,
        COMPLETE,
        NRC
    } state_t;

    typedef struct packed {
        logic [5:0]  index;
        logic [31:0] arg;
        logic [1:0]  rsp_type;
    } req_t;

    typedef struct packed {
        logic timeout;
        logic crc;
        logic end_bit;
        logic index;
    } status_t;

    // Only short responses echo the command index back in bits [37:32].
    function automatic logic has_index(input logic [1:0] rsp_type);
        return rsp_type[1];
    endfunction

endpackage

// File: rtl/cmd_queue_seq_if.sv
// rtl/cmd_queue_seq_if.sv - request enqueue handshake bundle
interface cmd_queue_seq_if;
    import cmd_seq_pkg::*;

    logic valid;
    logic ready;
    req_t data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/cmd_queue_fifo.sv
// rtl/cmd_queue_fifo.sv - command request FIFO with flush
module cmd_queue_fifo
    import cmd_seq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    cmd_queue_seq_if.slave  enq,
    input  logic            pop,
    input  logic            flush,
    output req_t            head,
    output logic            empty,
    output logic            full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    req_t           mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic           do_push;
    logic           do_pop;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign enq.ready = !full;
    // Flush wins over a same-cycle push or pop.
    assign do_push   = enq.valid && !full && !flush;
    assign do_pop    = pop && !empty && !flush;
    assign head      = mem[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= enq.data;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/cmd_queue_seq.sv
// rtl/cmd_queue_seq.sv - queued SD command issue/response sequencer with retry
module cmd_queue_seq
    import cmd_seq_pkg::*;
#(
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int NRC_CYCLES     = 8,
    parameter int MAX_RETRIES    = 2
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clk_en_p_i,
    input  logic         req_valid_i,
    output logic         req_ready_o,
    input  logic [5:0]   req_index_i,
    input  logic [31:0]  req_arg_i,
    input  logic [1:0]   req_rsp_type_i,
    output logic         tx_start_o,
    output logic [5:0]   tx_index_o,
    output logic [31:0]  tx_arg_o,
    input  logic         tx_done_i,
    output logic         rx_listen_o,
    output logic         rx_long_o,
    input  logic         rx_receiving_i,
    input  logic         rx_valid_i,
    input  logic [119:0] rx_rsp_i,
    input  logic         rx_crc_ok_i,
    input  logic         rx_end_bit_err_i,
    input  logic         dat0_i,
    input  logic         flush_i,
    output logic         cpl_valid_o,
    input  logic         cpl_ready_i,
    output logic [119:0] cpl_rsp_o,
    output logic [3:0]   cpl_status_o,
    output logic [1:0]   cpl_retries_o,
    output logic         busy_o
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int NW = $clog2(NRC_CYCLES + 1);

    cmd_queue_seq_if req_if ();

    state_t         state;
    req_t           cur;
    req_t           head;
    status_t        status;
    logic [1:0]     retries;
    logic [119:0]   rsp;
    logic [TW-1:0]  tmo_cnt;
    logic [NW-1:0]  nrc_cnt;
    logic           rx_seen;
    logic           rx_started;
    logic           retry_pend;
    logic           empty;
    logic           full;
    logic           pop;
    logic           reading;
    logic           got;
    logic           crc_now;
    logic           can_retry;
    logic           tmo_hit;
    logic           retry_now;

    assign req_if.valid = req_valid_i;
    assign req_if.data  = '{index: req_index_i, arg: req_arg_i, rsp_type: req_rsp_type_i};
    assign req_ready_o  = req_if.ready;

    cmd_queue_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .enq    (req_if),
        .pop    (pop),
        .flush  (flush_i),
        .head   (head),
        .empty  (empty),
        .full   (full)
    );

    assign pop       = (state == IDLE) && clk_en_p_i && !empty;
    assign reading   = (state == READ) || (state == READ_BUSY);
    // A response may land between strobes; remember it until the next strobe.
    assign got       = rx_valid_i || rx_seen;
    assign crc_now   = rx_valid_i ? ~rx_crc_ok_i : status.crc;
    assign can_retry = int'(retries) < MAX_RETRIES;
    assign tmo_hit   = !got && !rx_started && !rx_receiving_i
                       && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign retry_now = can_retry && (tmo_hit || (got && crc_now));

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state      <= IDLE;
            cur        <= '0;
            status     <= '0;
            retries    <= '0;
            rsp        <= '0;
            tmo_cnt    <= '0;
            nrc_cnt    <= '0;
            rx_seen    <= 1'b0;
            rx_started <= 1'b0;
            retry_pend <= 1'b0;
        end else begin
            if (reading && rx_valid_i) begin
                rsp            <= rx_rsp_i;
                rx_seen        <= 1'b1;
                status.crc     <= ~rx_crc_ok_i;
                status.end_bit <= rx_end_bit_err_i;
                status.index   <= has_index(cur.rsp_type) && (rx_rsp_i[37:32] != cur.index);
            end
            if (reading && clk_en_p_i) begin
                if (rx_receiving_i) begin
                    tmo_cnt    <= '0;
                    rx_started <= 1'b1;
                end else if (!rx_started && !got && !tmo_hit) begin
                    tmo_cnt <= tmo_cnt + TW'(1);
                end
            end

            case (state)
                IDLE: begin
                    if (pop) begin
                        cur     <= head;
                        retries <= '0;
                        status  <= '0;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (clk_en_p_i) state <= WRITE;
                end
                WRITE: begin
                    if (clk_en_p_i && tx_done_i) begin
                        state <= (cur.rsp_type == RSP_NONE) ? COMPLETE : SWITCH;
                    end
                end
                SWITCH: begin
                    if (clk_en_p_i) begin
                        state      <= (cur.rsp_type == RSP_BUSY) ? READ_BUSY : READ;
                        status     <= '0;
                        tmo_cnt    <= '0;
                        rx_seen    <= 1'b0;
                        rx_started <= 1'b0;
                    end
                end
                READ, READ_BUSY: begin
                    if (clk_en_p_i) begin
                        if (tmo_hit) status.timeout <= 1'b1;
                        if (retry_now) begin
                            retries    <= retries + 2'd1;
                            retry_pend <= 1'b1;
                            state      <= NRC;
                        end else if (tmo_hit || (got && (state == READ || dat0_i))) begin
                            state <= COMPLETE;
                        end
                    end
                end
                COMPLETE: begin
                    if (cpl_ready_i) state <= NRC;
                end
                NRC: begin
                    if (clk_en_p_i) begin
                        if (nrc_cnt == NW'(NRC_CYCLES - 1)) begin
                            nrc_cnt    <= '0;
                            retry_pend <= 1'b0;
                            state      <= retry_pend ? ISSUE : IDLE;
                        end else begin
                            nrc_cnt <= nrc_cnt + NW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign tx_start_o    = (state == ISSUE);
    assign tx_index_o    = cur.index;
    assign tx_arg_o      = cur.arg;
    assign rx_listen_o   = (state == SWITCH);
    assign rx_long_o     = (cur.rsp_type == RSP_LONG);
    assign cpl_valid_o   = (state == COMPLETE);
    assign cpl_rsp_o     = rsp;
    assign cpl_status_o  = status;
    assign cpl_retries_o = retries;
    assign busy_o        = !((state == IDLE) && empty);

endmodule

// File: tb/tb_cmd_queue_seq.sv
// tb/tb_cmd_queue_seq.sv - directed bench for cmd_queue_seq
module tb_cmd_queue_seq;
    import cmd_seq_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         clk_en = 1'b0;
    logic         tx_start, tx_done = 1'b0;
    logic [5:0]   tx_index;
    logic [31:0]  tx_arg;
    logic         rx_listen, rx_long;
    logic         rx_receiving = 1'b0, rx_valid = 1'b0;
    logic [119:0] rx_rsp = '0;
    logic         rx_crc_ok = 1'b1, rx_end_bit_err = 1'b0;
    logic         dat0 = 1'b1, flush = 1'b0;
    logic         cpl_valid, cpl_ready = 1'b0;
    logic [119:0] cpl_rsp;
    logic [3:0]   cpl_status;
    logic [1:0]   cpl_retries;
    logic         busy;

    int           n_vec = 0, n_err = 0;
    int           n_tx = 0, n_busy_cpl = 0, n_rsp = 0;
    int           crc_bad_upto = 0, busy_strobes = 0, write_delay = 0;
    logic         tx_prev = 1'b0, rd_silent = 1'b0;
    logic [5:0]   rsp_index = 6'd17, last_tx_idx = '0;
    logic [31:0]  rsp_word = '0, last_tx_arg = '0;
    int           base, div = 0;

    cmd_queue_seq_if req_if ();

    cmd_queue_seq #(.DEPTH(4), .TIMEOUT_CYCLES(64), .NRC_CYCLES(8), .MAX_RETRIES(2)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .clk_en_p_i       (clk_en),
        .req_valid_i      (req_if.valid),
        .req_ready_o      (req_if.ready),
        .req_index_i      (req_if.data.index),
        .req_arg_i        (req_if.data.arg),
        .req_rsp_type_i   (req_if.data.rsp_type),
        .tx_start_o       (tx_start),
        .tx_index_o       (tx_index),
        .tx_arg_o         (tx_arg),
        .tx_done_i        (tx_done),
        .rx_listen_o      (rx_listen),
        .rx_long_o        (rx_long),
        .rx_receiving_i   (rx_receiving),
        .rx_valid_i       (rx_valid),
        .rx_rsp_i         (rx_rsp),
        .rx_crc_ok_i      (rx_crc_ok),
        .rx_end_bit_err_i (rx_end_bit_err),
        .dat0_i           (dat0),
        .flush_i          (flush),
        .cpl_valid_o      (cpl_valid),
        .cpl_ready_i      (cpl_ready),
        .cpl_rsp_o        (cpl_rsp),
        .cpl_status_o     (cpl_status),
        .cpl_retries_o    (cpl_retries),
        .busy_o           (busy)
    );

    initial forever #5 clk = ~clk;

    // sd_clk strobe: one clk period in four.
    initial forever begin
        @(posedge clk);
        #2;
        div = (div + 1) % 4;
        clk_en = (div == 0);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_strobe();
        do @(negedge clk); while (!clk_en);
    endtask

    task automatic enq(input logic [5:0] idx, input logic [31:0] a, input logic [1:0] t);
        int n;
        n = 0;
        req_if.valid = 1'b1;
        req_if.data  = '{index: idx, arg: a, rsp_type: t};
        while (!req_if.ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        req_if.valid = 1'b0;
    endtask

    task automatic wait_cpl(input string tag, input int budget);
        int n;
        n = 0;
        while (!cpl_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_cpl_arrive"}, 32'(cpl_valid), 32'd1);
    endtask

    task automatic ack_cpl();
        cpl_ready = 1'b1;
        @(negedge clk);
        cpl_ready = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_busy_low"}, 32'(busy), 32'd0);
    endtask

    task automatic wait_ntx(input string tag, input int target, input int budget);
        int n;
        n = 0;
        while (n_tx < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_tx_start_seen"}, 32'(n_tx >= target), 32'd1);
    endtask

    initial forever begin
        @(negedge clk);
        if (tx_start && !tx_prev) begin
            n_tx++;
            last_tx_idx = tx_index;
            last_tx_arg = tx_arg;
        end
        tx_prev = tx_start;
        if (cpl_valid && !dat0) n_busy_cpl++;
    end

    // Command writer: finishes write_delay strobes after leaving ISSUE.
    initial forever begin
        @(negedge clk);
        if (tx_start) begin
            while (tx_start) @(negedge clk);
            repeat (write_delay) wait_strobe();
            tx_done = 1'b1;
            wait_strobe();
            @(negedge clk);
            tx_done = 1'b0;
        end
    end

    // Response reader: start bit after 3 strobes, 2 strobes of reception, then the frame.
    initial forever begin
        @(negedge clk);
        if (rx_listen) begin
            while (rx_listen) @(negedge clk);
            if (!rd_silent) begin
                repeat (3) wait_strobe();
                rx_receiving = 1'b1;
                repeat (2) wait_strobe();
                @(negedge clk);
                rx_receiving = 1'b0;
                rx_rsp = '0;
                rx_rsp[37:32] = rsp_index;
                rx_rsp[31:0]  = rsp_word;
                rx_crc_ok = (n_rsp >= crc_bad_upto);
                n_rsp++;
                rx_valid = 1'b1;
                if (busy_strobes > 0) dat0 = 1'b0;
                @(negedge clk);
                rx_valid = 1'b0;
                repeat (busy_strobes) wait_strobe();
                dat0 = 1'b1;
            end
        end
    end

    initial begin
        req_if.valid = 1'b0;
        req_if.data  = '0;
        repeat (4) @(negedge clk);
        chk("rst_req_ready", 32'(req_if.ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_tx_start", 32'(tx_start), 32'd0);
        chk("rst_rx_listen", 32'(rx_listen), 32'd0);
        chk("rst_cpl_valid", 32'(cpl_valid), 32'd0);
        chk("rst_cpl_status", 32'(cpl_status), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // CMD17 short response, clean
        base = n_tx; rsp_index = 6'd17; rsp_word = 32'h0000_0900;
        enq(6'd17, 32'h0000_1000, RSP_SHORT);
        wait_cpl("t1", 2000);
        chk("t1_tx_index", 32'(last_tx_idx), 32'd17);
        chk("t1_tx_arg", last_tx_arg, 32'h0000_1000);
        chk("t1_status", 32'(cpl_status), 32'h0);
        chk("t1_retries", 32'(cpl_retries), 32'd0);
        chk("t1_rsp", cpl_rsp[31:0], 32'h0000_0900);
        chk("t1_ntx", 32'(n_tx - base), 32'd1);
        ack_cpl();
        wait_idle("t1", 500);

        // No response at all: two reissues then timeout completion
        base = n_tx; rd_silent = 1'b1;
        enq(6'd17, 32'h0000_2000, RSP_SHORT);
        wait_cpl("t2", 5000);
        chk("t2_status", 32'(cpl_status), 32'h8);
        chk("t2_retries", 32'(cpl_retries), 32'd2);
        chk("t2_ntx", 32'(n_tx - base), 32'd3);
        ack_cpl();
        wait_idle("t2", 500);
        rd_silent = 1'b0;

        // One CRC failure then clean reissue
        base = n_tx; crc_bad_upto = n_rsp + 1; rsp_index = 6'd13; rsp_word = 32'h0000_0A00;
        enq(6'd13, 32'h0001_0000, RSP_SHORT);
        wait_cpl("t3", 3000);
        chk("t3_status", 32'(cpl_status), 32'h0);
        chk("t3_retries", 32'(cpl_retries), 32'd1);
        chk("t3_ntx", 32'(n_tx - base), 32'd2);
        chk("t3_rsp", cpl_rsp[31:0], 32'h0000_0A00);
        ack_cpl();
        wait_idle("t3", 500);

        // CMD7 with busy on DAT0 for 20 strobes
        base = n_busy_cpl; rsp_index = 6'd7; rsp_word = 32'h0000_0700; busy_strobes = 20;
        enq(6'd7, 32'h0001_0000, RSP_BUSY);
        wait_cpl("t4", 3000);
        chk("t4_cpl_while_busy", 32'(n_busy_cpl - base), 32'd0);
        chk("t4_status", 32'(cpl_status), 32'h0);
        chk("t4_rsp", cpl_rsp[31:0], 32'h0000_0700);
        ack_cpl();
        wait_idle("t4", 500);
        busy_strobes = 0;

        // Wrong index echoed: flagged, never retried
        base = n_tx; rsp_index = 6'd18; rsp_word = 32'h0000_0900;
        enq(6'd17, 32'h0000_1000, RSP_SHORT);
        wait_cpl("t5", 2000);
        chk("t5_status", 32'(cpl_status), 32'h1);
        chk("t5_retries", 32'(cpl_retries), 32'd0);
        chk("t5_ntx", 32'(n_tx - base), 32'd1);
        ack_cpl();
        wait_idle("t5", 500);
        rsp_index = 6'd17;

        // Fill: one in flight plus four queued, completions in order
        base = n_tx;
        enq(6'd1, 32'h0, RSP_NONE);
        wait_ntx("t6", base + 1, 500);
        enq(6'd2, 32'h0, RSP_NONE);
        enq(6'd3, 32'h0, RSP_NONE);
        enq(6'd4, 32'h0, RSP_NONE);
        chk("t6_ready_at3", 32'(req_if.ready), 32'd1);
        enq(6'd5, 32'h0, RSP_NONE);
        chk("t6_ready_at4", 32'(req_if.ready), 32'd0);
        chk("t6_busy", 32'(busy), 32'd1);
        for (int i = 1; i <= 5; i++) begin
            wait_cpl("t6", 1000);
            chk("t6_order", 32'(tx_index), 32'(i));
            chk("t6_status", 32'(cpl_status), 32'h0);
            ack_cpl();
        end
        wait_idle("t6", 500);
        chk("t6_ntx", 32'(n_tx - base), 32'd5);

        // Flush three queued entries during WRITE, with a same-cycle push
        base = n_tx; write_delay = 12;
        enq(6'd17, 32'h0000_3000, RSP_SHORT);
        wait_ntx("t7", base + 1, 500);
        while (tx_start) @(negedge clk);
        enq(6'd20, 32'h0, RSP_NONE);
        enq(6'd21, 32'h0, RSP_NONE);
        enq(6'd22, 32'h0, RSP_NONE);
        flush = 1'b1;
        req_if.valid = 1'b1;
        req_if.data  = '{index: 6'd23, arg: 32'h0, rsp_type: RSP_NONE};
        @(negedge clk);
        flush = 1'b0;
        req_if.valid = 1'b0;
        chk("t7_busy_inflight", 32'(busy), 32'd1);
        wait_cpl("t7", 2000);
        chk("t7_index", 32'(tx_index), 32'd17);
        chk("t7_status", 32'(cpl_status), 32'h0);
        ack_cpl();
        wait_idle("t7", 500);
        repeat (200) @(negedge clk);
        chk("t7_ntx", 32'(n_tx - base), 32'd1);
        chk("t7_no_cpl", 32'(cpl_valid), 32'd0);
        chk("t7_idle", 32'(busy), 32'd0);
        write_delay = 0;

        // Reset in the middle of a long-response command
        rd_silent = 1'b1;
        enq(6'd2, 32'hCAFE_0002, RSP_LONG);
        begin
            int n;
            n = 0;
            while (!rx_listen && n < 500) begin
                @(negedge clk);
                n++;
            end
        end
        chk("t8_rx_long", 32'(rx_long), 32'd1);
        chk("t8_tx_arg", tx_arg, 32'hCAFE_0002);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t8_rst_rx_long", 32'(rx_long), 32'd0);
        chk("t8_rst_tx_arg", tx_arg, 32'h0);
        chk("t8_rst_busy", 32'(busy), 32'd0);
        chk("t8_rst_req_ready", 32'(req_if.ready), 32'd1);
        chk("t8_rst_rx_listen", 32'(rx_listen), 32'd0);
        rst_n = 1'b1;
        rd_silent = 1'b0;
        repeat (4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
